uart_rx: RTL and testbench

Serial receiver for the MipsCPU console port: deserialises 8N1 asynchronous frames arriving on `RxD` into bytes for the CPU's memory-mapped serial interface. It is the counterpart of the existing transmitter that drives `TxD`. It sits between the top-level `RxD` pin and the serial status/data registers, which read bytes through a valid/ack handshake.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud divisor and byte width.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned UART_DATA_W               = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: samples RxD at bit centres and hands bytes to the CPU
// through a valid/ack register pair, flagging framing errors and overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                   clk_init,
    input  logic                   rst_init,
    input  logic                   RxD,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ack,
    output logic                   rx_frame_err,
    output logic                   rx_overrun,
    output logic                   rx_busy
);

    localparam int unsigned HALF   = CLKS_PER_BIT / 2;
    localparam int unsigned TCNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned DW     = UART_DATA_W;

    logic s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk_init),
        .rst_n (rst_init),
        .d     (RxD),
        .q     (s)
    );

    rx_state_e         state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic [DW-1:0]     data_q, data_d;
    logic              deliver_q, deliver_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;
    logic              tick;

    // State and datapath registers
    always_ff @(posedge clk_init or negedge rst_init) begin
        if (!rst_init) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            deliver_q <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            deliver_q <= deliver_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign tick = (tcnt_q == '0);

    // Frame sequencing: counters, shifting and end-of-frame events
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d = START;
                    tcnt_d  = TCNT_W'(HALF - 1);
                end
            end
            START: begin
                if (!tick) begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end else if (s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    tcnt_d  = TCNT_W'(CLKS_PER_BIT - 1);
                    bcnt_d  = 3'd7;
                end
            end
            DATA: begin
                if (!tick) begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end else begin
                    shift_d = {s, shift_q[DW-1:1]};
                    tcnt_d  = TCNT_W'(CLKS_PER_BIT - 1);
                    if (bcnt_q == 3'd0) begin
                        state_d = STOP;
                    end else begin
                        bcnt_d = bcnt_q - 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end else if (s) begin
                    deliver_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Consumer handshake; a same-cycle ack frees the register for the new byte
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        busy_d  = (state_d != IDLE);
        if (deliver_q) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a byte scoreboard.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;

    logic       clk_init = 1'b0;
    logic       rst_init;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_init     (clk_init),
        .rst_init     (rst_init),
        .RxD          (RxD),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 clk_init = ~clk_init;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk_init) cyc <= cyc + 1;

    always @(negedge clk_init) begin
        if (rx_frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_overrun) ov_cnt <= ov_cnt + 1;
        if (rx_frame_err && rx_overrun) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk_init);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk_init);
        end
        RxD = stop_bit;
        repeat (CPB) @(negedge clk_init);
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!rx_valid && n < max_cyc) begin
            @(negedge clk_init);
            n++;
        end
        chk("valid_timeout", 32'(rx_valid), 32'd1);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk_init);
        rx_ack = 1'b0;
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return 8'hxx;
    endfunction

    int t0, t_valid, fe0, ov0, target;
    logic busy_seen, valid_seen;
    logic [7:0] rb;

    initial begin
        rst_init = 1'b0;
        RxD      = 1'b1;
        rx_ack   = 1'b0;
        repeat (3) @(negedge clk_init);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(rx_frame_err), 32'd0);
        chk("rst_ovr", 32'(rx_overrun), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        rst_init = 1'b1;
        repeat (2) @(negedge clk_init);

        // Single frame: latency, data, handshake clear
        exp_q.push_back(8'hA5);
        t0 = cyc + 1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_valid(200);
                t_valid = cyc;
            end
        join
        chk("a5_latency", 32'(t_valid - t0), 32'd155);
        chk("a5_data", 32'(rx_data), 32'(pop_exp()));
        chk("a5_ferr_cnt", 32'(fe_cnt), 32'd0);
        chk("a5_ovr_cnt", 32'(ov_cnt), 32'd0);
        ack_pulse();
        chk("a5_ack_clears", 32'(rx_valid), 32'd0);

        // Short low glitch is rejected
        fe0 = fe_cnt; ov0 = ov_cnt;
        busy_seen = 1'b0; valid_seen = 1'b0;
        RxD = 1'b0;
        repeat (4) begin
            @(negedge clk_init);
            busy_seen |= rx_busy;
        end
        RxD = 1'b1;
        repeat (30) begin
            @(negedge clk_init);
            busy_seen |= rx_busy;
            valid_seen |= rx_valid;
        end
        chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
        chk("glitch_busy_end", 32'(rx_busy), 32'd0);
        chk("glitch_valid", 32'(valid_seen), 32'd0);
        chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
        chk("glitch_ovr", 32'(ov_cnt - ov0), 32'd0);

        // Framing error, line held low, then recovery
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk_init);
        RxD = 1'b1;
        repeat (2 * CPB) @(negedge clk_init);
        chk("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("ferr_no_valid", 32'(rx_valid), 32'd0);
        chk("ferr_busy_idle", 32'(rx_busy), 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_valid(50);
        chk("after_break_data", 32'(rx_data), 32'(pop_exp()));
        ack_pulse();

        // Back-to-back without ack: second byte dropped with overrun
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk_init);
        chk("ovr_data_kept", 32'(rx_data), 32'(pop_exp()));
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
        ack_pulse();
        chk("ovr_ack_clears", 32'(rx_valid), 32'd0);

        // Back-to-back with ack in the exact delivery cycle: reload, no overrun
        ov0 = ov_cnt;
        t0 = cyc + 1;
        exp_q.push_back(8'h22);
        target = t0 + 10 * CPB + 154;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                while (cyc < target) @(negedge clk_init);
                rx_ack = 1'b1;
                @(negedge clk_init);
                rx_ack = 1'b0;
                chk("sameack_data", 32'(rx_data), 32'(pop_exp()));
                chk("sameack_valid", 32'(rx_valid), 32'd1);
            end
        join
        repeat (4) @(negedge clk_init);
        chk("sameack_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        ack_pulse();

        // Reset in the middle of bit 4 of 0xFF
        RxD = 1'b0;
        repeat (CPB) @(negedge clk_init);
        RxD = 1'b1;
        repeat (4 * CPB + HALF) @(negedge clk_init);
        rst_init = 1'b0;
        #1;
        chk("midrst_data", 32'(rx_data), 32'h00);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_ferr", 32'(rx_frame_err), 32'd0);
        chk("midrst_ovr", 32'(rx_overrun), 32'd0);
        chk("midrst_busy", 32'(rx_busy), 32'd0);
        repeat (3) @(negedge clk_init);
        rst_init = 1'b1;
        repeat (6 * CPB) @(negedge clk_init);
        chk("midrst_no_byte", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_valid(50);
        chk("midrst_5a", 32'(rx_data), 32'(pop_exp()));
        ack_pulse();

        // 256 random back-to-back bytes with immediate ack
        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    rb = 8'($urandom);
                    exp_q.push_back(rb);
                    send_frame(rb, 1'b1);
                end
            end
            begin
                for (int j = 0; j < 256; j++) begin
                    wait_valid(400);
                    chk("rand_data", 32'(rx_data), 32'(pop_exp()));
                    ack_pulse();
                end
            end
        join
        repeat (CPB) @(negedge clk_init);
        chk("rand_ferr", 32'(fe_cnt - fe0), 32'd0);
        chk("rand_ovr", 32'(ov_cnt - ov0), 32'd0);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
